// File: rtl/mem_pkg.sv
// Shared types and defaults for the data-memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEFAULT_DEPTH       = 64;
  localparam int DEFAULT_WAIT_CYCLES = 2;

  // A request is rejected when misaligned or past the last stored word.
  function automatic logic addr_err(input logic [31:0] addr, input int depth);
    return (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(depth));
  endfunction

endpackage

// File: rtl/ram_1rw.sv
// Single-port word storage: synchronous write, asynchronous read, never reset.
module ram_1rw #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request at a time, waits WAIT_CYCLES,
// then pulses a single-cycle response; storage lives in ram_1rw.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t        state;
  state_t        next_state;
  logic [3:0]    cnt;
  logic          lat_we;
  logic          lat_err;
  logic [AW-1:0] lat_idx;
  logic [31:0]   lat_wdata;
  logic          ram_we;
  logic [31:0]   ram_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= 32'd0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_we    <= req_we;
            lat_err   <= addr_err(req_addr, DEPTH);
            lat_idx   <= req_addr[AW+1:2];
            lat_wdata <= req_wdata;
            cnt       <= WAIT_LOAD;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          cnt <= 4'd0;
        end
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          next_state = (WAIT_CYCLES > 0) ? WAIT : RESP;
        end else begin
          next_state = IDLE;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          next_state = RESP;
        end else begin
          next_state = WAIT;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs decode purely from registered state; the write commits on the edge leaving RESP.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'd0;
    ram_we     = 1'b0;
    case (state)
      IDLE: req_ready = 1'b1;
      WAIT: req_ready = 1'b0;
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = lat_err;
        if (!lat_err && !lat_we) begin
          resp_rdata = ram_rdata;
        end else begin
          resp_rdata = 32'd0;
        end
        ram_we = lat_we && !lat_err && !reset;
      end
      default: req_ready = 1'b0;
    endcase
  end

  ram_1rw #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (lat_idx),
    .wdata (lat_wdata),
    .rdata (ram_rdata)
  );

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
Parameters:
REQ-001 SHALL provide parameter DEPTH, default 64, number of 32-bit words stored.
REQ-002 SHALL provide parameter WAIT_CYCLES, default 2, wait states inserted between request accept and response (legal range 0..15).

Ports:
REQ-003 SHALL provide clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide req_valid  input  1  initiator presents a request.
REQ-006 SHALL provide req_we  input  1  1 = write, 0 = read.
REQ-007 SHALL provide req_addr  input  32  byte address from the core's memory-stage ALU result.
REQ-008 SHALL provide req_wdata  input  32  store data.
REQ-009 SHALL provide req_ready  output  1  responder can accept a request this cycle.
REQ-010 SHALL provide resp_valid  output  1  one-cycle pulse marking a completed response.
REQ-011 SHALL provide resp_rdata  output  32  read data, valid only while resp_valid=1.
REQ-012 SHALL provide resp_err  output  1  request rejected, valid only while resp_valid=1.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 SHALL assert req_ready only in IDLE; a request is accepted when req_valid=1 and req_ready=1 on a rising edge.
REQ-015 SHALL latch req_we, req_addr and req_wdata on accept and ignore request inputs until back in IDLE.
REQ-016 SHALL move IDLE->WAIT on accept when WAIT_CYCLES>0, loading the wait counter with WAIT_CYCLES-1; IDLE->RESP directly when WAIT_CYCLES=0.
REQ-017 SHALL decrement the wait counter each cycle in WAIT and move WAIT->RESP on the cycle the counter reads 0.
REQ-018 SHALL assert resp_valid for exactly one cycle in RESP, then move RESP->IDLE unconditionally.
REQ-019 SHALL produce resp_valid exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-020 SHALL index storage with word index req_addr[31:2]; an error is latched req_addr[1:0]!=0 or word index >= DEPTH.
REQ-021 SHALL, for a read without error, drive resp_rdata with the stored word during RESP.
REQ-022 SHALL, for a write without error, update the stored word on the edge that ends RESP and drive resp_rdata=0.
REQ-023 SHALL, on error, assert resp_err=1, drive resp_rdata=0 and leave storage unchanged.
REQ-024 SHALL drive resp_rdata=0 and resp_err=0 whenever resp_valid=0.
REQ-025 SHALL reject a request held high during RESP until the following IDLE cycle: at most one accept per WAIT_CYCLES+2 cycles.
REQ-026 SHALL let a read issued after a write to the same word return the new data.

Reset
REQ-027 SHALL force state IDLE, wait counter 0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0 on any edge with reset=1.
REQ-028 SHALL abandon a pending request on reset mid-operation: no response, no write.
REQ-029 SHALL leave storage contents unchanged by reset.

Structure
REQ-030 SHALL take the state enum (IDLE, WAIT, RESP) and the default DEPTH and WAIT_CYCLES constants from shared package mem_pkg.
REQ-031 SHALL hold storage in one sub-module ram_1rw (single port, synchronous write, asynchronous read); the FSM and counter stay in dmem_responder.

Verification
REQ-032 SHALL cover: reset, then write 0xDEADBEEF to 0x10 -> resp_valid 3 cycles after accept, resp_err=0; read 0x10 -> resp_rdata=0xDEADBEEF.
REQ-033 SHALL cover: read 0x12 (misaligned) -> resp_err=1, resp_rdata=0; a later read of 0x10 is unchanged.
REQ-034 SHALL cover: write to 0x100 with DEPTH=64 (word 64) -> resp_err=1; word 0 not overwritten (aliasing check).
REQ-035 SHALL cover: req_valid held high for 20 cycles with default parameters -> exactly 5 accepts, req_ready low in WAIT and RESP.
REQ-036 SHALL cover: WAIT_CYCLES=0, read 0x0 -> resp_valid on the cycle after accept.
REQ-037 SHALL cover: reset asserted in WAIT of a write of 0x1234 to 0x20 -> no resp_valid, word at 0x20 keeps its prior value.
